fft_reorder: RTL and testbench

Streaming bit-reversal reorder buffer placed directly after the final radix-2^2 SDF stage of the FFT pipeline. The SDF chain emits each N-point frame in bit-reversed bin order. This block writes each frame into one half of a ping-pong memory at bit-reversed addresses and reads the other half in natural order. Downstream logic therefore receives bins 0..N-1 in sequence. Throughput is continuous: one sample per clock, with back-to-back frames and no stalls.

---
 rtl/fft_reorder.sv | 146 ++++++++++++++
 tb/tb_fft_reorder.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_reorder.sv
// fft_reorder: streaming bit-reversal reorder buffer.
// Each N-point frame arriving in bit-reversed bin order is written into one
// half of a ping-pong memory at bit-reversed addresses, while the other half
// is read out in natural order. One sample per clock, no stalls.
module fft_reorder #(
  parameter int N     = 64,
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             di_en,
  input  logic [WIDTH-1:0] di_re,
  input  logic [WIDTH-1:0] di_im,
  output logic             do_en,
  output logic [WIDTH-1:0] do_re,
  output logic [WIDTH-1:0] do_im
);

  localparam int LOG_N = $clog2(N);
  localparam logic [LOG_N-1:0] CNT_LAST = LOG_N'(N - 1);
  localparam logic [LOG_N-1:0] CNT_ONE  = LOG_N'(1);
  localparam logic [LOG_N-1:0] CNT_ZERO = LOG_N'(0);

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } state_t;

  // Reverse all LOG_N bits of an index.
  function automatic logic [LOG_N-1:0] bitrev(input logic [LOG_N-1:0] x);
    logic [LOG_N-1:0] r;
    r = CNT_ZERO;
    for (int i = 0; i < LOG_N; i++) begin
      r[i] = x[LOG_N-1-i];
    end
    return r;
  endfunction

  // Ping-pong storage: the bank bit is the address MSB.
  logic [2*WIDTH-1:0] mem_r [0:2*N-1];

  logic [LOG_N-1:0]   wr_count_r;
  logic               wr_bank_r;
  logic               rd_start_r;
  state_t             state_r;
  logic [LOG_N-1:0]   rd_count_r;
  logic               rd_bank_r;
  logic               do_en_r;
  logic [WIDTH-1:0]   do_re_r;
  logic [WIDTH-1:0]   do_im_r;

  logic [LOG_N:0]     wr_addr_s;
  logic [LOG_N:0]     rd_addr_s;
  logic [2*WIDTH-1:0] rd_word_s;

  assign wr_addr_s = {wr_bank_r, bitrev(wr_count_r)};
  assign rd_addr_s = {rd_bank_r, rd_count_r};
  assign rd_word_s = mem_r[rd_addr_s];

  // Write-side sequencing: sample counter, bank select and frame-done pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_count_r <= CNT_ZERO;
      wr_bank_r  <= 1'b0;
      rd_start_r <= 1'b0;
    end else if (di_en) begin
      if (wr_count_r == CNT_LAST) begin
        wr_count_r <= CNT_ZERO;
        wr_bank_r  <= ~wr_bank_r;
        rd_start_r <= 1'b1;
      end else begin
        wr_count_r <= wr_count_r + CNT_ONE;
        rd_start_r <= 1'b0;
      end
    end else begin
      // A dropped enable discards any partial frame; the bank is reused.
      wr_count_r <= CNT_ZERO;
      rd_start_r <= 1'b0;
    end
  end

  // Sample storage; contents are deliberately not reset.
  always_ff @(posedge clock) begin
    if (di_en && !reset) begin
      mem_r[wr_addr_s] <= {di_re, di_im};
    end
  end

  // Read-side FSM: streams a completed bank out in natural order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      rd_count_r <= CNT_ZERO;
      rd_bank_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (rd_start_r) begin
            state_r    <= READ;
            rd_count_r <= CNT_ZERO;
            // wr_bank_r has already toggled, so the finished bank is its inverse.
            rd_bank_r  <= ~wr_bank_r;
          end
        end
        READ: begin
          if (rd_count_r == CNT_LAST) begin
            rd_count_r <= CNT_ZERO;
            if (rd_start_r) begin
              rd_bank_r <= ~wr_bank_r;
            end else begin
              state_r <= IDLE;
            end
          end else begin
            rd_count_r <= rd_count_r + CNT_ONE;
          end
        end
        default: begin
          state_r    <= IDLE;
          rd_count_r <= CNT_ZERO;
        end
      endcase
    end
  end

  // Output register doubles as the synchronous memory read stage.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      do_en_r <= 1'b0;
      do_re_r <= {WIDTH{1'b0}};
      do_im_r <= {WIDTH{1'b0}};
    end else if (state_r == READ) begin
      do_en_r <= 1'b1;
      do_re_r <= rd_word_s[2*WIDTH-1:WIDTH];
      do_im_r <= rd_word_s[WIDTH-1:0];
    end else begin
      do_en_r <= 1'b0;
      do_re_r <= {WIDTH{1'b0}};
      do_im_r <= {WIDTH{1'b0}};
    end
  end

  assign do_en = do_en_r;
  assign do_re = do_re_r;
  assign do_im = do_im_r;

endmodule

// File: tb/tb_fft_reorder.sv
// Testbench for fft_reorder: an N=8 and an N=64 instance share clock and
// reset. Stimulus pushes expected (cycle, data) pairs into per-instance
// queues; monitors pop and compare whenever do_en is high.
module tb_fft_reorder;

  typedef struct {
    int          stamp;
    logic [31:0] data;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        di_en8 = 1'b0, di_en64 = 1'b0;
  logic [15:0] di_re8 = 16'h0, di_im8 = 16'h0, di_re64 = 16'h0, di_im64 = 16'h0;
  logic        do_en8, do_en64;
  logic [15:0] do_re8, do_im8, do_re64, do_im64;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t exp8[$];
  exp_t exp64[$];
  logic [31:0] cur8[$];
  logic [31:0] cur64[$];

  fft_reorder #(.N(8), .WIDTH(16)) u8 (
    .clock(clock), .reset(reset), .di_en(di_en8), .di_re(di_re8), .di_im(di_im8),
    .do_en(do_en8), .do_re(do_re8), .do_im(do_im8));

  fft_reorder #(.N(64), .WIDTH(16)) u64 (
    .clock(clock), .reset(reset), .di_en(di_en64), .di_re(di_re64), .di_im(di_im64),
    .do_en(do_en64), .do_re(do_re64), .do_im(do_im64));

  always #5 clock = ~clock;

  // Posedge counter used to time-stamp expected outputs.
  always @(posedge clock) cyc <= cyc + 1;

  function automatic int bitrev(input int x, input int bits);
    int r = 0;
    for (int i = 0; i < bits; i++) if (x[i]) r = r | (1 << (bits - 1 - i));
    return r;
  endfunction

  // Reference: a completed frame's bin j is input sample bitrev(j); bin 0
  // appears two edges after the last input edge, then one bin per cycle.
  task automatic drive8(input bit en, input logic [15:0] re, input logic [15:0] im);
    exp_t e;
    @(negedge clock);
    di_en8 = en; di_re8 = re; di_im8 = im;
    if (!reset) begin
      if (!en) cur8.delete();
      else begin
        cur8.push_back({re, im});
        if (cur8.size() == 8) begin
          for (int j = 0; j < 8; j++) begin
            e.stamp = cyc + 3 + j;
            e.data  = cur8[bitrev(j, 3)];
            exp8.push_back(e);
          end
          cur8.delete();
        end
      end
    end
  endtask

  task automatic drive64(input bit en, input logic [15:0] re, input logic [15:0] im);
    exp_t e;
    @(negedge clock);
    di_en64 = en; di_re64 = re; di_im64 = im;
    if (!reset) begin
      if (!en) cur64.delete();
      else begin
        cur64.push_back({re, im});
        if (cur64.size() == 64) begin
          for (int j = 0; j < 64; j++) begin
            e.stamp = cyc + 3 + j;
            e.data  = cur64[bitrev(j, 6)];
            exp64.push_back(e);
          end
          cur64.delete();
        end
      end
    end
  endtask

  // Monitor for the N=8 instance.
  always @(negedge clock) begin
    exp_t e;
    if (do_en8) begin
      total++;
      if (exp8.size() == 0) begin
        bad++;
        $display("FAIL u8_unexpected cyc=%0d got=%h expected no output", cyc, {do_re8, do_im8});
      end else begin
        e = exp8.pop_front();
        if (e.stamp != cyc || e.data != {do_re8, do_im8}) begin
          bad++;
          $display("FAIL u8_data cyc=%0d got=%h expected=%h at cyc %0d", cyc, {do_re8, do_im8}, e.data, e.stamp);
        end
      end
    end else begin
      total++;
      if (do_re8 != 16'h0 || do_im8 != 16'h0) begin
        bad++;
        $display("FAIL u8_idle_zero cyc=%0d got=%h expected 0", cyc, {do_re8, do_im8});
      end
      if (exp8.size() != 0 && exp8[0].stamp <= cyc) begin
        e = exp8.pop_front();
        bad++;
        $display("FAIL u8_missing cyc=%0d do_en=0 expected=%h", cyc, e.data);
      end
    end
  end

  // Monitor for the N=64 instance.
  always @(negedge clock) begin
    exp_t e;
    if (do_en64) begin
      total++;
      if (exp64.size() == 0) begin
        bad++;
        $display("FAIL u64_unexpected cyc=%0d got=%h expected no output", cyc, {do_re64, do_im64});
      end else begin
        e = exp64.pop_front();
        if (e.stamp != cyc || e.data != {do_re64, do_im64}) begin
          bad++;
          $display("FAIL u64_data cyc=%0d got=%h expected=%h at cyc %0d", cyc, {do_re64, do_im64}, e.data, e.stamp);
        end
      end
    end else begin
      total++;
      if (do_re64 != 16'h0 || do_im64 != 16'h0) begin
        bad++;
        $display("FAIL u64_idle_zero cyc=%0d got=%h expected 0", cyc, {do_re64, do_im64});
      end
      if (exp64.size() != 0 && exp64[0].stamp <= cyc) begin
        e = exp64.pop_front();
        bad++;
        $display("FAIL u64_missing cyc=%0d do_en=0 expected=%h", cyc, e.data);
      end
    end
  end

  initial begin
    logic [15:0] v;
    // Reset state, with di_en held high during reset (must be ignored).
    drive8(1'b1, 16'h1111, 16'h2222);
    drive64(1'b1, 16'h3333, 16'h4444);
    total++;
    if ({do_en8, do_re8, do_im8, do_en64, do_re64, do_im64} != 66'h0) begin
      bad++;
      $display("FAIL reset_state got=%h expected 0", {do_en8, do_re8, do_im8, do_en64, do_re64, do_im64});
    end
    @(negedge clock);
    reset = 1'b0; di_en8 = 1'b0; di_en64 = 1'b0;

    // Single ramp frame, im = -re.
    for (int k = 0; k < 8; k++) drive8(1'b1, 16'(k), 16'h0 - 16'(k));
    repeat (3) drive8(1'b0, 16'h0, 16'h0);

    // Partial frame of 5 samples, 3 idle, then a full ramp.
    for (int k = 0; k < 5; k++) drive8(1'b1, 16'(50 + k), 16'(60 + k));
    repeat (3) drive8(1'b0, 16'h0, 16'h0);
    for (int k = 0; k < 8; k++) drive8(1'b1, 16'(k), 16'h0 - 16'(k));
    repeat (12) drive8(1'b0, 16'h0, 16'h0);

    // Extreme values alternating on re/im, back-to-back with a random frame.
    for (int k = 0; k < 8; k++)
      drive8(1'b1, k[0] ? 16'h7FFF : 16'h8000, k[0] ? 16'h8000 : 16'h7FFF);
    for (int k = 0; k < 8; k++) drive8(1'b1, 16'($urandom), 16'($urandom));
    drive8(1'b0, 16'h0, 16'h0);

    // Three gapped frames with a one-cycle idle between them.
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 8; k++) drive8(1'b1, 16'($urandom), 16'($urandom));
      drive8(1'b0, 16'h0, 16'h0);
    end
    repeat (12) drive8(1'b0, 16'h0, 16'h0);

    // Reset during the 4th output of a frame.
    for (int k = 0; k < 8; k++) drive8(1'b1, 16'(200 + k), 16'(300 + k));
    drive8(1'b0, 16'h0, 16'h0);
    repeat (5) @(posedge clock);
    #1;
    total++;
    if (do_en8 !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset_do_en got=%b expected 1", do_en8);
    end
    #1;
    reset = 1'b1;
    exp8.delete();
    cur8.delete();
    #1;
    total++;
    if ({do_en8, do_re8, do_im8} != 33'h0) begin
      bad++;
      $display("FAIL mid_reset_outputs got=%h expected 0", {do_en8, do_re8, do_im8});
    end
    drive8(1'b1, 16'hDEAD, 16'hBEEF);
    drive8(1'b1, 16'hDEAD, 16'hBEEF);
    @(negedge clock);
    reset = 1'b0; di_en8 = 1'b0;
    for (int k = 0; k < 8; k++) drive8(1'b1, 16'($urandom), 16'($urandom));
    repeat (12) drive8(1'b0, 16'h0, 16'h0);

    // Random enable pattern: partial frames, gaps and back-to-back runs.
    for (int c = 0; c < 200; c++) begin
      v = 16'($urandom);
      drive8($urandom_range(0, 9) != 0, v, 16'($urandom));
    end
    repeat (12) drive8(1'b0, 16'h0, 16'h0);

    // N=64: four back-to-back frames, re = 100*f + k.
    for (int f = 0; f < 4; f++)
      for (int k = 0; k < 64; k++) drive64(1'b1, 16'(100 * f + k), 16'($urandom));
    drive64(1'b0, 16'h0, 16'h0);
    // A partial then two random frames with a random gap.
    for (int k = 0; k < 40; k++) drive64(1'b1, 16'($urandom), 16'($urandom));
    drive64(1'b0, 16'h0, 16'h0);
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < 64; k++) drive64(1'b1, 16'($urandom), 16'($urandom));
      repeat ($urandom_range(1, 4)) drive64(1'b0, 16'h0, 16'h0);
    end
    repeat (80) drive64(1'b0, 16'h0, 16'h0);

    // Every expected output must have been seen.
    total++;
    if (exp8.size() != 0) begin
      bad++;
      $display("FAIL u8_drain left=%0d expected 0", exp8.size());
    end
    total++;
    if (exp64.size() != 0) begin
      bad++;
      $display("FAIL u64_drain left=%0d expected 0", exp64.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
